// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the EX-stage load/store request engine:
// access sizes, FSM states, base strobe masks and the misalignment test.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_DONE   = 2'd2,
        ST_CANCEL = 2'd3
    } lsu_state_e;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] base_strb(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic ale_check(input logic [1:0] size, input logic [2:0] offset);
        return |(offset & align_mask(size));
    endfunction

endpackage

// File: rtl/ex_mem_req_unit_if.sv
// SRAM-like split request/response bus between the EX-stage engine and memory.
interface ex_mem_req_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane placement: offset, write strobes and replicated store data.
// Without LSU_ALE_CHECK_EN the offset is forced to natural alignment for the size.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]        i_size,
    input  logic              i_is_store,
    input  logic [OFF_W-1:0]  i_addr_lo,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [OFF_W-1:0]  o_offset,
    output logic [NB-1:0]     o_wstrb,
    output logic [DATA_W-1:0] o_wdata
);

    logic [2:0]    w_mask;
    logic [NB-1:0] w_base;

    always_comb begin
        w_mask = align_mask(i_size);
        w_base = NB'(base_strb(i_size));
`ifdef LSU_ALE_CHECK_EN
        o_offset = i_addr_lo;
`else
        o_offset = i_addr_lo & ~w_mask[OFF_W-1:0];
`endif
        o_wstrb = i_is_store ? (w_base << o_offset) : '0;
        // Each lane takes the source byte at its position modulo the access size.
        o_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            o_wdata[8*i +: 8] = i_wdata[8*(i & int'(w_mask)) +: 8];
        end
    end

endmodule

// File: rtl/ex_mem_req_unit.sv
// EX-stage load/store request engine: one-entry stage register, split-bus request FSM,
// outstanding/discard tracking across flushes. Optional macro: LSU_ALE_CHECK_EN.
module ex_mem_req_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_is_mem,
    input  logic                        in_is_store,
    input  logic [1:0]                  in_size,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic [DATA_W-1:0]           in_wdata,
    input  logic                        in_excp,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_excp_ale,
    output logic [$clog2(DATA_W/8)-1:0] out_offset,
    output logic                        out_mem_issued,
    ex_mem_req_unit_if.master           bus,
    output logic                        data_ok_discard,
    output logic [CNT_W-1:0]            outstanding
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    lsu_state_e          r_state, w_state_nx;
    logic                r_valid;
    logic                r_is_mem, r_is_store, r_excp;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                r_bus_wr;
    logic [1:0]          r_bus_size;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [NB-1:0]       r_bus_wstrb;
    logic [DATA_W-1:0]   r_bus_wdata;

    logic [CNT_W-1:0]    r_outstanding, r_discard;
    logic [CNT_W-1:0]    w_out_nx, w_disc_nx;

    logic [OFF_W-1:0]    w_offset;
    logic [NB-1:0]       w_wstrb;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_ale, w_bypass, w_req, w_accept, w_ready_go;
    logic                w_handoff, w_can_issue, w_issue, w_load;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_size     (r_size),
        .i_is_store (r_is_store),
        .i_addr_lo  (r_addr[OFF_W-1:0]),
        .i_wdata    (r_wdata),
        .o_offset   (w_offset),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata)
    );

`ifdef LSU_ALE_CHECK_EN
    assign w_ale = r_valid && r_is_mem && ale_check(r_size, 3'(r_addr[OFF_W-1:0]));
`else
    assign w_ale = 1'b0;
`endif

    assign w_bypass    = !r_is_mem || w_ale || r_excp;
    assign w_req       = (r_state == ST_REQ) || (r_state == ST_CANCEL);
    assign w_accept    = w_req && bus.addr_ok;
    // In CANCEL the bus acceptance belongs to the dropped request, never to the stage.
    assign w_ready_go  = w_bypass || (r_state == ST_DONE) || ((r_state == ST_REQ) && bus.addr_ok);
    assign in_ready    = !r_valid || (w_ready_go && out_ready);
    assign out_valid   = r_valid && w_ready_go && !flush;
    assign w_handoff   = out_valid && out_ready;
    assign w_load      = in_valid && in_ready;
    assign w_can_issue = r_outstanding < MAX_CNT;

    assign out_excp_ale   = w_ale;
    assign out_offset     = w_offset;
    assign out_mem_issued = r_valid && !w_bypass;

    assign bus.req   = w_req;
    assign bus.wr    = r_bus_wr;
    assign bus.size  = r_bus_size;
    assign bus.addr  = r_bus_addr;
    assign bus.wstrb = r_bus_wstrb;
    assign bus.wdata = r_bus_wdata;

    always_comb begin
        w_state_nx = r_state;
        w_issue    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!flush && r_valid && !w_bypass && w_can_issue) begin
                    w_state_nx = ST_REQ;
                    w_issue    = 1'b1;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    w_state_nx = bus.addr_ok ? ST_IDLE : ST_CANCEL;
                end else if (bus.addr_ok) begin
                    w_state_nx = out_ready ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_CANCEL: begin
                if (bus.addr_ok) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // A flush marks every request still owed a data_ok as discardable, including
    // one accepted this cycle; a data_ok arriving with the flush is discarded directly.
    always_comb begin
        w_out_nx = r_outstanding + CNT_W'(w_accept) - CNT_W'(bus.data_ok);
        if (flush) begin
            w_disc_nx = w_out_nx;
        end else begin
            w_disc_nx = r_discard
                      + CNT_W'((r_state == ST_CANCEL) && bus.addr_ok)
                      - CNT_W'(bus.data_ok && (r_discard != '0));
        end
    end

    assign data_ok_discard = bus.data_ok && (flush || (r_discard != '0));
    assign outstanding     = r_outstanding;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_valid       <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_bus_wstrb   <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_outstanding <= w_out_nx;
            r_discard     <= w_disc_nx;
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
            end else if (w_handoff) begin
                r_valid <= 1'b0;
            end
            if (w_issue) begin
                r_bus_wstrb <= w_wstrb;
            end
        end
    end

    // Bus fields are captured at issue so they stay stable through REQ/CANCEL.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_is_mem   <= in_is_mem;
            r_is_store <= in_is_store;
            r_size     <= in_size;
            r_addr     <= in_addr;
            r_wdata    <= in_wdata;
            r_excp     <= in_excp;
        end
        if (w_issue) begin
            r_bus_wr    <= r_is_store;
            r_bus_size  <= r_size;
            r_bus_addr  <= {r_addr[ADDR_W-1:OFF_W], w_offset};
            r_bus_wdata <= w_wdata;
        end
    end

endmodule

// File: tb/tb_ex_mem_req_unit.sv
// Directed bench for ex_mem_req_unit: 32-bit and 64-bit instances, bus/handoff scoreboards.
module tb_ex_mem_req_unit;
    import lsu_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic       ale;
        logic       issued;
        logic [1:0] off;
    } out_exp_t;

    bus_exp_t bus_q[$];
    out_exp_t out_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        in_valid, in_ready, in_is_mem, in_is_store, in_excp, flush;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic        out_valid, out_ready, out_excp_ale, out_mem_issued, data_ok_discard;
    logic [1:0]  out_offset;
    logic [2:0]  outstanding;
    ex_mem_req_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();

    ex_mem_req_unit #(.DATA_W(32), .ADDR_W(32), .MAX_OUTSTANDING(2), .CNT_W(3)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem),
        .in_is_store(in_is_store), .in_size(in_size), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_excp(in_excp), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_excp_ale(out_excp_ale),
        .out_offset(out_offset), .out_mem_issued(out_mem_issued), .bus(bus32),
        .data_ok_discard(data_ok_discard), .outstanding(outstanding)
    );

    // 64-bit instance
    logic        in_valid64, in_ready64, in_is_mem64, in_is_store64, in_excp64, flush64;
    logic [1:0]  in_size64;
    logic [31:0] in_addr64;
    logic [63:0] in_wdata64;
    logic        out_valid64, out_ready64, out_excp_ale64, out_mem_issued64, data_ok_discard64;
    logic [2:0]  out_offset64;
    logic [2:0]  outstanding64;
    ex_mem_req_unit_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    ex_mem_req_unit #(.DATA_W(64), .ADDR_W(32), .MAX_OUTSTANDING(2), .CNT_W(3)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_is_mem(in_is_mem64),
        .in_is_store(in_is_store64), .in_size(in_size64), .in_addr(in_addr64),
        .in_wdata(in_wdata64), .in_excp(in_excp64), .flush(flush64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_excp_ale(out_excp_ale64),
        .out_offset(out_offset64), .out_mem_issued(out_mem_issued64), .bus(bus64),
        .data_ok_discard(data_ok_discard64), .outstanding(outstanding64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bus(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                            input logic [3:0] st, input logic [31:0] d);
        bus_q.push_back('{wr: wr, size: sz, addr: a, wstrb: st, wdata: d});
    endtask

    task automatic push_out(input logic ale, input logic iss, input logic [1:0] off);
        out_q.push_back('{ale: ale, issued: iss, off: off});
    endtask

    task automatic send32(input logic st, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic ex);
        in_valid = 1'b1; in_is_mem = 1'b1; in_is_store = st; in_size = sz;
        in_addr = a; in_wdata = d; in_excp = ex;
        #1 chk("in_ready_at_send", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0; in_excp = 1'b0;
    endtask

    task automatic wait_req32();
        int n = 0;
        while (bus32.req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("req32_within_budget", (n < 20), 1'b1);
    endtask

    task automatic accept_req32();
        wait_req32();
        bus32.addr_ok = 1'b1;
        cyc();
        bus32.addr_ok = 1'b0;
    endtask

    task automatic resp32(input logic exp_disc, input string tag);
        bus32.data_ok = 1'b1;
        #1 chk(tag, data_ok_discard, exp_disc);
        cyc();
        bus32.data_ok = 1'b0;
    endtask

    task automatic op64(input logic [1:0] sz, input logic [31:0] a, input logic [63:0] d,
                        input logic [31:0] exp_a, input logic [7:0] exp_s, input logic [63:0] exp_d);
        int n = 0;
        in_valid64 = 1'b1; in_is_mem64 = 1'b1; in_is_store64 = 1'b1;
        in_size64 = sz; in_addr64 = a; in_wdata64 = d;
        cyc();
        in_valid64 = 1'b0;
        while (bus64.req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("req64_within_budget", (n < 20), 1'b1);
        #1;
        chk("addr64", bus64.addr, exp_a);
        chk("wstrb64", bus64.wstrb, exp_s);
        chk("wdata64", bus64.wdata, exp_d);
        bus64.addr_ok = 1'b1;
        #1 chk("out_valid64_on_accept", out_valid64, 1'b1);
        cyc();
        bus64.addr_ok = 1'b0;
        bus64.data_ok = 1'b1;
        cyc();
        bus64.data_ok = 1'b0;
        #1 chk("outstanding64_drained", outstanding64, 3'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus32.req && bus32.addr_ok) begin
                chk("bus_expected", (bus_q.size() != 0), 1'b1);
                if (bus_q.size() != 0) begin
                    bus_exp_t e;
                    e = bus_q.pop_front();
                    chk("bus_wr", bus32.wr, e.wr);
                    chk("bus_size", bus32.size, e.size);
                    chk("bus_addr", bus32.addr, e.addr);
                    chk("bus_wstrb", bus32.wstrb, e.wstrb);
                    chk("bus_wdata", bus32.wdata, e.wdata);
                end
            end
            if (out_valid && out_ready) begin
                chk("out_expected", (out_q.size() != 0), 1'b1);
                if (out_q.size() != 0) begin
                    out_exp_t o;
                    o = out_q.pop_front();
                    chk("out_excp_ale", out_excp_ale, o.ale);
                    chk("out_mem_issued", out_mem_issued, o.issued);
                    chk("out_offset", out_offset, o.off);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_valid = 0; in_is_mem = 0; in_is_store = 0; in_size = 0; in_addr = 0;
        in_wdata = 0; in_excp = 0; flush = 0; out_ready = 1;
        bus32.addr_ok = 0; bus32.data_ok = 0;
        in_valid64 = 0; in_is_mem64 = 0; in_is_store64 = 0; in_size64 = 0; in_addr64 = 0;
        in_wdata64 = 0; in_excp64 = 0; flush64 = 0; out_ready64 = 1;
        bus64.addr_ok = 0; bus64.data_ok = 0;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_req", bus32.req, 1'b0);
        chk("rst_wstrb", bus32.wstrb, 4'h0);
        chk("rst_outstanding", outstanding, 3'd0);
        chk("rst_discard", data_ok_discard, 1'b0);
        chk("rst_req64", bus64.req, 1'b0);

        // Store word, addr_ok held back two cycles.
        push_bus(1'b1, SZ_W, 32'h1004, 4'hF, 32'h1234_5678);
        push_out(1'b0, 1'b1, 2'd0);
        send32(1'b1, SZ_W, 32'h1004, 32'h1234_5678, 1'b0);
        #1 chk("sw_idle_no_req", bus32.req, 1'b0);
        chk("sw_idle_in_ready", in_ready, 1'b0);
        cyc(); #1 chk("sw_req_c1", bus32.req, 1'b1);
        chk("sw_no_out_c1", out_valid, 1'b0);
        cyc(); #1 chk("sw_req_c2", bus32.req, 1'b1);
        cyc();
        bus32.addr_ok = 1'b1;
        #1 chk("sw_req_c3", bus32.req, 1'b1);
        chk("sw_out_valid_on_accept", out_valid, 1'b1);
        cyc();
        bus32.addr_ok = 1'b0;
        #1 chk("sw_outstanding_1", outstanding, 3'd1);
        chk("sw_req_dropped", bus32.req, 1'b0);
        cyc(); cyc();
        #1 chk("sw_outstanding_held", outstanding, 3'd1);
        resp32(1'b0, "sw_data_ok_kept");
        #1 chk("sw_outstanding_0", outstanding, 3'd0);

        // Store byte to lane 3.
        push_bus(1'b1, SZ_B, 32'h1003, 4'b1000, 32'hABAB_ABAB);
        push_out(1'b0, 1'b1, 2'd3);
        send32(1'b1, SZ_B, 32'h1003, 32'h0000_00AB, 1'b0);
        accept_req32();
        resp32(1'b0, "sb_data_ok_kept");

        // Misaligned load half.
`ifdef LSU_ALE_CHECK_EN
        push_out(1'b1, 1'b0, 2'd1);
        send32(1'b0, SZ_H, 32'h1001, 32'h0, 1'b0);
        #1 chk("lh_ale_out_valid", out_valid, 1'b1);
        chk("lh_ale_no_req", bus32.req, 1'b0);
        cyc(); #1 chk("lh_ale_no_req_after", bus32.req, 1'b0);
`else
        push_bus(1'b0, SZ_H, 32'h1000, 4'h0, 32'h0);
        push_out(1'b0, 1'b1, 2'd0);
        send32(1'b0, SZ_H, 32'h1001, 32'h0, 1'b0);
        accept_req32();
        resp32(1'b0, "lh_aligned_data_ok");
`endif

        // Upstream exception bypasses the bus.
        push_out(1'b0, 1'b0, 2'd0);
        send32(1'b0, SZ_W, 32'h0400, 32'h0, 1'b1);
        #1 chk("excp_out_valid", out_valid, 1'b1);
        chk("excp_no_req", bus32.req, 1'b0);
        cyc(); #1 chk("excp_no_req_after", bus32.req, 1'b0);

        // Third load stalls at the outstanding limit.
        push_bus(1'b0, SZ_W, 32'h0100, 4'h0, 32'h0); push_out(1'b0, 1'b1, 2'd0);
        send32(1'b0, SZ_W, 32'h0100, 32'h0, 1'b0);
        accept_req32();
        push_bus(1'b0, SZ_W, 32'h0104, 4'h0, 32'h0); push_out(1'b0, 1'b1, 2'd0);
        send32(1'b0, SZ_W, 32'h0104, 32'h0, 1'b0);
        accept_req32();
        push_bus(1'b0, SZ_W, 32'h0108, 4'h0, 32'h0); push_out(1'b0, 1'b1, 2'd0);
        send32(1'b0, SZ_W, 32'h0108, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_no_req", bus32.req, 1'b0);
            chk("stall_outstanding_2", outstanding, 3'd2);
            cyc();
        end
        resp32(1'b0, "stall_first_data_ok");
        accept_req32();
        resp32(1'b0, "stall_second_data_ok");
        resp32(1'b0, "stall_third_data_ok");
        #1 chk("stall_outstanding_0", outstanding, 3'd0);

        // Flush while the request waits for addr_ok.
        push_bus(1'b1, SZ_W, 32'h0200, 4'hF, 32'hCAFE_F00D);
        send32(1'b1, SZ_W, 32'h0200, 32'hCAFE_F00D, 1'b0);
        wait_req32();
        flush = 1'b1;
        #1 chk("fl_no_out_valid", out_valid, 1'b0);
        cyc();
        flush = 1'b0;
        #1 chk("fl_req_held", bus32.req, 1'b1);
        chk("fl_in_ready", in_ready, 1'b1);
        cyc();
        bus32.addr_ok = 1'b1;
        #1 chk("fl_accept_no_out_valid", out_valid, 1'b0);
        cyc();
        bus32.addr_ok = 1'b0;
        #1 chk("fl_outstanding_1", outstanding, 3'd1);
        chk("fl_req_released", bus32.req, 1'b0);
        resp32(1'b1, "fl_data_ok_discarded");
        #1 chk("fl_outstanding_0", outstanding, 3'd0);

        // Flush with two outstanding and a same-cycle data_ok.
        push_bus(1'b0, SZ_W, 32'h0300, 4'h0, 32'h0); push_out(1'b0, 1'b1, 2'd0);
        send32(1'b0, SZ_W, 32'h0300, 32'h0, 1'b0);
        accept_req32();
        push_bus(1'b0, SZ_W, 32'h0304, 4'h0, 32'h0); push_out(1'b0, 1'b1, 2'd0);
        send32(1'b0, SZ_W, 32'h0304, 32'h0, 1'b0);
        accept_req32();
        flush = 1'b1;
        bus32.data_ok = 1'b1;
        #1 chk("f2_same_cycle_discard", data_ok_discard, 1'b1);
        chk("f2_outstanding_2", outstanding, 3'd2);
        cyc();
        flush = 1'b0;
        bus32.data_ok = 1'b0;
        #1 chk("f2_outstanding_1", outstanding, 3'd1);
        cyc();
        resp32(1'b1, "f2_next_discard");
        #1 chk("f2_outstanding_0", outstanding, 3'd0);
        push_bus(1'b0, SZ_W, 32'h0308, 4'h0, 32'h0); push_out(1'b0, 1'b1, 2'd0);
        send32(1'b0, SZ_W, 32'h0308, 32'h0, 1'b0);
        accept_req32();
        resp32(1'b0, "f2_after_drain_kept");

        // 64-bit datapath.
        op64(SZ_D, 32'h2008, 64'h1122_3344_5566_7788, 32'h2008, 8'hFF, 64'h1122_3344_5566_7788);
        op64(SZ_B, 32'h2005, 64'h0000_0000_0000_005A, 32'h2005, 8'h20, 64'h5A5A_5A5A_5A5A_5A5A);
`ifdef LSU_ALE_CHECK_EN
        in_valid64 = 1'b1; in_is_mem64 = 1'b1; in_is_store64 = 1'b1;
        in_size64 = SZ_D; in_addr64 = 32'h200C; in_wdata64 = 64'h1122_3344_5566_7788;
        cyc();
        in_valid64 = 1'b0;
        #1 chk("d64_ale_out_valid", out_valid64, 1'b1);
        chk("d64_ale_flag", out_excp_ale64, 1'b1);
        chk("d64_ale_no_req", bus64.req, 1'b0);
        chk("d64_ale_offset", out_offset64, 3'd4);
        cyc();
`else
        op64(SZ_D, 32'h200C, 64'h1122_3344_5566_7788, 32'h2008, 8'hFF, 64'h1122_3344_5566_7788);
`endif

        cyc();
        chk("bus_q_drained", bus_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
